// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - opcodes, fetch entry/state types and the static branch predictor
package fetch_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } pred_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_t;

  // Backward-taken/forward-taken alike: every beq/bne/j/jal is predicted taken.
  function automatic pred_t predict_target(input logic [31:0] pc, input logic [31:0] instr);
    pred_t       p;
    logic [31:0] pc4;
    logic [31:0] off;
    pc4      = pc + 32'd4;
    off      = {{14{instr[15]}}, instr[15:0], 2'b00};
    p.taken  = 1'b0;
    p.target = pc4;
    case (instr[31:26])
      OP_BEQ, OP_BNE: begin
        p.taken  = 1'b1;
        p.target = pc4 + off;
      end
      OP_J, OP_JAL: begin
        p.taken  = 1'b1;
        p.target = {pc4[31:28], instr[25:0], 2'b00};
      end
      OP_SPECIAL: if (instr[5:0] == FUNCT_JR) p.taken = 1'b0;
      default: p.taken = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry FIFO of fetched {pc,instr} pairs with flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// rtl/fetch_predict_unit.sv - PC owner, imem request issue, static predecode and redirect flush
module fetch_predict_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        miss,
  input  logic [31:0] rpc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_inflight;
  logic          r_live;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_used;
  logic          w_full;
  logic          w_empty;
  logic          w_credit;
  logic          w_issue;
  logic          w_arrive;
  logic          w_push;
  logic          w_predict;
  logic          w_pop;
  pred_t         w_pred;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  // Credit counts the word already in flight so a response always has a slot.
  assign w_used      = w_count + CW'(r_inflight);
  assign w_credit    = !w_full && (w_used < CW'(DEPTH));
  assign w_pred      = predict_target(r_inflight_pc, imem_rdata);
  assign w_push_data = '{pc: r_inflight_pc, instr: imem_rdata};
  assign w_pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (miss)                     w_state_nxt = ST_RUN;
    else if (w_predict)           w_state_nxt = ST_SQUASH;
    else if (r_state == ST_STALL) w_state_nxt = w_pop ? ST_RUN : ST_STALL;
    else if (!w_credit)           w_state_nxt = ST_STALL;
    else                          w_state_nxt = ST_RUN;
  end

  // SQUASH covers exactly the cycle in which the sequential word behind a taken prediction lands.
  always_comb begin
    w_arrive  = r_inflight && (r_state != ST_SQUASH);
    w_issue   = r_live && !miss && w_credit;
    w_push    = w_arrive && !miss;
    w_predict = w_push && w_pred.taken;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_live        <= 1'b0;
    end else begin
      r_live     <= 1'b1;
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
      if (miss)           r_pc <= rpc;
      else if (w_predict) r_pc <= w_pred.target;
      else if (w_issue)   r_pc <= r_pc + 32'd4;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .resetn      (resetn),
    .i_flush     (miss),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign imem_en   = w_issue;
  assign imem_addr = r_pc;
  assign out_valid = !w_empty;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// tb/tb_fetch_predict_unit.sv - directed scoreboard bench for fetch_predict_unit
module tb_fetch_predict_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        miss = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];
  logic [31:0] issued[$];
  logic [31:0] prog [logic [31:0]];
  logic        s_en;
  logic        s_ov;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  fetch_predict_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .miss       (miss),
    .rpc        (rpc),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return prog.exists(a) ? prog[a] : 32'h0;
  endfunction

  // Architectural next fetch address under static always-taken prediction.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] seq;
    logic [31:0] simm;
    seq = pc + 32'd4;
    simm = 32'($signed(w[15:0]));
    case (w[31:26])
      6'd4, 6'd5: return seq + (simm << 2);
      6'd2, 6'd3: return {seq[31:28], w[25:0], 2'b00};
      default:    return seq;
    endcase
  endfunction

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    exp_t        e;
    pc = start;
    for (int i = 0; i < n; i++) begin
      e.pc    = pc;
      e.instr = mem_rd(pc);
      sb.push_back(e);
      pc = next_pc(pc, e.instr);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] issued_after(input logic [31:0] a, input logic [31:0] skip);
    for (int i = 0; i < issued.size(); i++)
      if (issued[i] == a)
        for (int j = i + 1; j < issued.size(); j++)
          if (issued[j] != skip) return issued[j];
    return 32'hdead_dead;
  endfunction

  // Entered at posedge+1 with inputs set; samples the cycle, scores transfers, serves imem.
  task automatic cycle();
    exp_t e;
    #1;
    s_en    = imem_en;
    s_addr  = imem_addr;
    s_ov    = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;
    if (s_ov && out_ready) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_underflow observed=pc %h expected=no transfer", s_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("xfer_pc", s_pc, e.pc);
        check("xfer_instr", s_instr, e.instr);
      end
    end
    if (miss) begin
      sb.delete();
      push_stream(rpc, 48);
    end
    if (s_en) issued.push_back(s_addr);
    @(posedge clk);
    #1;
    imem_rdata = s_en ? mem_rd(s_addr) : $urandom;
  endtask

  task automatic wait_issue(input logic [31:0] a, input int budget, input string tag);
    int found;
    found = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      cycle();
      if (s_en && s_addr == a) found = 1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    prog[32'h10]   = 32'h1000_0003;
    prog[32'h40]   = 32'h0800_0100;
    prog[32'h404]  = 32'h03e0_0008;
    prog[32'h420]  = 32'h0fff_ffff;
    prog[32'h1010] = 32'h1420_fff0;
    prog[32'h2010] = 32'h1400_fffe;

    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_en", 32'(imem_en), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);

    push_stream(32'h0, 64);
    out_ready = 1'b1;
    resetn = 1'b1;
    cycle();
    check("t1_release_en", 32'(s_en), 32'd0);
    cycle();
    check("t1_first_en", 32'(s_en), 32'd1);
    check("t1_first_addr", s_addr, 32'h0);
    check("t1_first_ov", 32'(s_ov), 32'd0);
    cycle();
    check("t1_second_addr", s_addr, 32'h4);
    check("t1_second_ov", 32'(s_ov), 32'd0);
    cycle();
    check("t1_ov_rises", 32'(s_ov), 32'd1);
    check("t1_head_pc", s_pc, 32'h0);

    wait_issue(32'h0fff_fffc, 300, "t2_reach_jal_target");
    check("t1_issue2", issued[2], 32'h8);
    check("t2_beq_next", issued_after(32'h10, 32'h14), 32'h20);
    check("t3_j_next", issued_after(32'h40, 32'h44), 32'h400);
    check("t3_jr_seq", issued_after(32'h404, 32'hffff_ffff), 32'h408);
    check("t3_jal_next", issued_after(32'h420, 32'h424), 32'h0fff_fffc);

    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i >= 6) begin
        check("t4_en_full", 32'(s_en), 32'd0);
        check("t4_ov_full", 32'(s_ov), 32'd1);
        check("t4_head_stable", s_pc, sb[0].pc);
      end
    end
    out_ready = 1'b1;
    repeat (8) cycle();

    for (int i = 0; i < 20 && !s_en; i++) cycle();
    check("t5_found_issue", 32'(s_en), 32'd1);
    out_ready = 1'b0;
    miss = 1'b1;
    rpc = 32'h1000;
    cycle();
    check("t5_en_in_miss", 32'(s_en), 32'd0);
    miss = 1'b0;
    cycle();
    check("t5_ov_after_miss", 32'(s_ov), 32'd0);
    check("t5_en_after_miss", 32'(s_en), 32'd1);
    check("t5_addr_after_miss", s_addr, 32'h1000);

    out_ready = 1'b1;
    wait_issue(32'h1010, 40, "t6_reach_bne");
    miss = 1'b1;
    rpc = 32'h2000;
    cycle();
    check("t6_en_in_miss", 32'(s_en), 32'd0);
    miss = 1'b0;
    cycle();
    check("t6_en_after_miss", 32'(s_en), 32'd1);
    check("t6_addr_after_miss", s_addr, 32'h2000);
    repeat (30) cycle();
    check("t6_bne_back", issued_after(32'h2010, 32'h2014), 32'h200c);

    out_ready = 1'b0;
    repeat (6) cycle();
    check("t6_stalled_ov", 32'(s_ov), 32'd1);
    resetn = 1'b0;
    #1;
    check("t6_rst_en", 32'(imem_en), 32'd0);
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_ov", 32'(out_valid), 32'd0);
    check("t6_rst_pc", out_pc, 32'h0);
    check("t6_rst_instr", out_instr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
